// File: rtl/ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit
//
// Iterative RV32M multiply/divide unit for the EX stage. One operation at a
// time: shift-add multiply and restoring divide on operand magnitudes, with
// sign correction and special-case results applied in a final FIX cycle.
//
// FSM: IDLE -> PREP -> CALC -> FIX -> IDLE
//   IDLE : start (without flush) is accepted; operands and funct3 captured.
//   PREP : magnitudes and result signs recorded; first iteration step runs.
//   CALC : remaining N-1 iteration steps (N = XLEN / BITS_PER_CYCLE).
//   FIX  : sign fix-up, half/quotient/remainder select, done pulse.
// done lands N+1 edges after the start-sampling edge (N+2 cycles total).
//
// Parameters
//   XLEN            operand/result width (default 32)
//   BITS_PER_CYCLE  product/quotient bits per iteration: 1, 2 or 4;
//                   XLEN must be a multiple and XLEN/BITS_PER_CYCLE >= 2
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   asynchronous, active-high reset
//   flush   in   abort current operation; blocks a start while idle
//   start   in   request a new operation (sampled in IDLE only)
//   funct3  in   000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                100 DIV, 101 DIVU, 110 REM,  111 REMU
//   op_a    in   rs1 operand
//   op_b    in   rs2 operand
//   busy    out  operation in progress (combinationally high on accept)
//   done    out  one-cycle completion pulse
//   result  out  operation result, valid with done and held until the
//                next completed operation
//
// Optional build macro
//   MULDIV_EARLY_OUT_EN : divide-by-zero, signed overflow and op_a == 0
//                         bypass CALC (PREP -> FIX), done in cycle 3.
// ---------------------------------------------------------------------------
module ex_muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;

  // Captured operation
  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q, b_q;

  // Iteration datapath: hi = partial product high / remainder,
  // lo = multiplier remaining / dividend-then-quotient, bm = |op_b|.
  logic [XLEN-1:0] hi_q, lo_q, bm_q;
  logic            q_neg_q, r_neg_q;
  logic [XLEN-1:0] result_q;

  // -------------------------------------------------------------------------
  // Operand decode (from captured operands, stable from PREP onwards)
  // -------------------------------------------------------------------------
  logic            is_div;
  logic            a_signed, b_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, a_zero;
  logic            skip_calc;
  logic            accept;

  assign is_div = op_q[2];

  always_comb begin
    // NOTE: every signal driven in always_comb gets a default first so no
    // path through the case can leave it unassigned and infer a latch.
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op_q)
      3'b000, 3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
      3'b010:                         begin a_signed = 1'b1; b_signed = 1'b0; end
      default:                        begin a_signed = 1'b0; b_signed = 1'b0; end
    endcase
  end

  assign a_neg = a_signed & a_q[XLEN-1];
  assign b_neg = b_signed & b_q[XLEN-1];
  // Negating the most-negative value wraps to itself, which read as unsigned
  // is exactly its magnitude.
  assign a_mag = a_neg ? (~a_q + 1'b1) : a_q;
  assign b_mag = b_neg ? (~b_q + 1'b1) : b_q;

  assign div_zero = is_div && (b_q == '0);
  assign div_ovf  = ((op_q == 3'b100) || (op_q == 3'b110)) &&
                    (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
  assign a_zero   = (a_q == '0);

`ifdef MULDIV_EARLY_OUT_EN
  assign skip_calc = div_zero | div_ovf | a_zero;
`else
  assign skip_calc = 1'b0;
`endif

  assign accept = (state_q == IDLE) && start && !flush;

  // -------------------------------------------------------------------------
  // FSM: state register and next-state / handshake outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      // The first step runs in PREP, so CALC starts counting at 1 and
      // leaves after step N-1.
      if (state_q == PREP)      cnt_q <= CW'(1);
      else if (state_q == CALC) cnt_q <= cnt_q + CW'(1);
      else                      cnt_q <= '0;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        // busy rises in the accepting cycle itself so upstream stalls
        // without inserting a bubble.
        if (accept) begin
          state_d = PREP;
          busy    = 1'b1;
        end
      end
      PREP: begin
        busy = 1'b1;
        if (flush)          state_d = IDLE;
        else if (skip_calc) state_d = FIX;
        else                state_d = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (flush)                       state_d = IDLE;
        else if (cnt_q == CW'(N - 1))    state_d = FIX;
      end
      FIX: begin
        busy    = 1'b1;
        done    = !flush;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Iteration step: BITS_PER_CYCLE shift-add or restoring-divide steps.
  // PREP feeds the freshly formed magnitudes, CALC feeds the registers.
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] s_hi, s_lo, s_b;
  logic [XLEN:0]   sum_t, rem_t;

  always_comb begin
    // NOTE: blocking assignments here are deliberate; each loop pass must
    // see the value produced by the previous pass within the same cycle.
    s_hi  = (state_q == PREP) ? '0    : hi_q;
    s_lo  = (state_q == PREP) ? a_mag : lo_q;
    s_b   = (state_q == PREP) ? b_mag : bm_q;
    sum_t = '0;
    rem_t = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (is_div) begin
        rem_t = {s_hi, s_lo[XLEN-1]};
        s_lo  = {s_lo[XLEN-2:0], 1'b0};
        if (rem_t >= {1'b0, s_b}) begin
          rem_t   = rem_t - {1'b0, s_b};
          s_lo[0] = 1'b1;
        end
        s_hi = rem_t[XLEN-1:0];
      end else begin
        sum_t        = {1'b0, s_hi} + (s_lo[0] ? {1'b0, s_b} : '0);
        {s_hi, s_lo} = {sum_t, s_lo[XLEN-1:1]};
      end
    end
  end

  // NOTE: the operand/iteration registers carry no reset; they are always
  // written before being read, and only result and control need a defined
  // post-reset value.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= funct3;
      a_q  <= op_a;
      b_q  <= op_b;
    end
    if (state_q == PREP) begin
      bm_q    <= b_mag;
      q_neg_q <= a_neg ^ b_neg;
      r_neg_q <= a_neg;
    end
    if ((state_q == PREP) || (state_q == CALC)) begin
      hi_q <= s_hi;
      lo_q <= s_lo;
    end
  end

  // -------------------------------------------------------------------------
  // FIX: sign correction, result select and special cases
  // -------------------------------------------------------------------------
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_value;

  assign prod   = {hi_q, lo_q};
  assign prod_s = q_neg_q ? (~prod + 1'b1) : prod;
  assign quo_s  = q_neg_q ? (~lo_q + 1'b1) : lo_q;
  assign rem_s  = r_neg_q ? (~hi_q + 1'b1) : hi_q;

  always_comb begin
    fix_value = '0;
    if (div_zero)
      fix_value = op_q[1] ? a_q : '1;
    else if (a_zero)
      fix_value = '0;
    else if (div_ovf)
      fix_value = op_q[1] ? '0 : a_q;
    else if (!is_div)
      fix_value = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    else
      fix_value = op_q[1] ? rem_s : quo_s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     result_q <= '0;
    else if (done) result_q <= fix_value;
  end

  // Present the fresh value during the done cycle, the held value otherwise.
  assign result = done ? fix_value : result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv_unit
//
// Directed bench for ex_muldiv_unit (XLEN=32, BITS_PER_CYCLE=1, N=32).
// Cycle numbering: the cycle in which start is driven is cycle 1, so a
// normal operation raises done in cycle 34. Special cases finish in cycle 3
// when MULDIV_EARLY_OUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_ex_muldiv_unit;

  localparam int XLEN = 32;
  localparam int LAT  = 34;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_SP = 3;
`else
  localparam int LAT_SP = 34;
`endif

  logic            clk;
  logic            reset;
  logic            flush;
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a, op_b;
  logic            busy, done;
  logic [XLEN-1:0] result;

  int checks = 0;
  int errors = 0;

  ex_muldiv_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(1)) dut (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one operation from an idle cycle (entered just after a rising
  // edge) and follows it to done. poke > 0 re-asserts start with other
  // operands in that cycle, which must be ignored. Returns in the cycle
  // after done, with the unit idle.
  task automatic run_op(input string tag, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat,
                        input int poke);
    int cyc;
    bit busy_ok;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    #1;
    check({tag, " busy_in_start_cycle"}, {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    start   = 1'b0;
    op_a    = ~a;
    op_b    = ~b;
    cyc     = 2;
    busy_ok = 1'b1;
    while (!done && cyc < 80) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (cyc == poke) begin
        start  = 1'b1;
        funct3 = 3'b000;
        op_a   = 32'd9;
        op_b   = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check({tag, " done_cycle"}, 32'(cyc), 32'(exp_lat));
    check({tag, " busy_through_done"}, {31'b0, busy_ok & busy}, 32'd1);
    check({tag, " result"}, result, exp_res);
    @(posedge clk); #1;
    check({tag, " done_single_pulse"}, {31'b0, done}, 32'd0);
    check({tag, " busy_after_done"}, {31'b0, busy}, 32'd0);
    check({tag, " result_held"}, result, exp_res);
  endtask

  initial begin
    bit done_seen;
    reset  = 1'b1;
    flush  = 1'b0;
    start  = 1'b0;
    funct3 = 3'b000;
    op_a   = '0;
    op_b   = '0;
    #2;
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset result", result, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Multiply family (start pulse mid-operation must be ignored)
    run_op("mul_7x-3",      3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT, 5);
    run_op("mulhu_ffxff",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT, 0);
    run_op("mulh_ffxff",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, LAT, 0);
    run_op("mulhsu_m1xff",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT, 0);
    run_op("mul_shift",     3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, LAT, 12);
    run_op("mul_zero_a",    3'b000, 32'd0,        32'd5,         32'd0,         LAT_SP, 0);

    // Divide family
    run_op("div_-20/3",     3'b100, 32'hFFFF_FFEC, 32'd3,        32'hFFFF_FFFA, LAT, 0);
    run_op("rem_-20/3",     3'b110, 32'hFFFF_FFEC, 32'd3,        32'hFFFF_FFFE, LAT, 0);
    run_op("div_20/-3",     3'b100, 32'd20,       32'hFFFF_FFFD, 32'hFFFF_FFFA, LAT, 0);
    run_op("rem_20/-3",     3'b110, 32'd20,       32'hFFFF_FFFD, 32'd2,         LAT, 0);
    run_op("divu_big/16",   3'b101, 32'hFFFF_FFF0, 32'd16,       32'h0FFF_FFFF, LAT, 0);
    run_op("remu_big%7",    3'b111, 32'hFFFF_FFF0, 32'd7,        32'd2,         LAT, 0);

    // Divide by zero and signed overflow
    run_op("divu_100/0",    3'b101, 32'd100,      32'd0,         32'hFFFF_FFFF, LAT_SP, 0);
    run_op("remu_100/0",    3'b111, 32'd100,      32'd0,         32'd100,       LAT_SP, 0);
    run_op("div_-7/0",      3'b100, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFFF, LAT_SP, 0);
    run_op("rem_-7/0",      3'b110, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, LAT_SP, 0);
    run_op("div_ovf",       3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SP, 0);
    run_op("rem_ovf",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_SP, 0);

    // flush together with start in IDLE: nothing starts, result held (0)
    funct3 = 3'b000; op_a = 32'd6; op_b = 32'd6;
    start = 1'b1; flush = 1'b1;
    #1;
    check("flush_start busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start no_op", {31'b0, busy | done}, 32'd0);
    check("flush_start result", result, 32'd0);

    // Flush in cycle 10 of a DIVU: idle in cycle 11, no done, result held
    funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd10;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_seen = 1'b0;
    for (int c = 2; c < 10; c++) begin
      if (done) done_seen = 1'b1;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    #1;
    if (done) done_seen = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy_cycle11", {31'b0, busy}, 32'd0);
    check("flush no_done", {31'b0, done_seen | done}, 32'd0);
    check("flush result_held", result, 32'd0);
    run_op("divu_after_flush", 3'b101, 32'd1000, 32'd10, 32'd100, LAT, 0);

    // Reset in the middle of CALC, then a normal operation
    funct3 = 3'b000; op_a = 32'd3; op_b = 32'd4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (13) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset busy", {31'b0, busy}, 32'd0);
    check("midreset done", {31'b0, done}, 32'd0);
    check("midreset result", result, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset idle", {31'b0, busy | done}, 32'd0);
    run_op("mul_after_reset", 3'b000, 32'd3, 32'd4, 32'd12, LAT, 0);
    run_op("b2b_second",      3'b011, 32'h0001_0000, 32'h0001_0000, 32'd1, LAT, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
